// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if: loader, CPU read and SRAM pin bundle
// for the program/data SRAM access controller.
interface sram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) ();
  logic                  run_not_prog;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic                  ld_done;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  cpu_rd_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_rd_ready;
  logic                  cpu_rd_valid;
  logic [DATA_WIDTH-1:0] cpu_rd_data;
  logic                  sram_ce_bar;
  logic                  sram_we_bar;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wr_data;
  logic [DATA_WIDTH-1:0] sram_rd_data;

  modport master (
    output run_not_prog, ld_valid, ld_data,
    output cpu_rd_req, cpu_addr, sram_rd_data,
    input  ld_ready, ld_done, ld_addr,
    input  cpu_rd_ready, cpu_rd_valid, cpu_rd_data,
    input  sram_ce_bar, sram_we_bar, sram_addr, sram_wr_data
  );

  modport slave (
    input  run_not_prog, ld_valid, ld_data,
    input  cpu_rd_req, cpu_addr, sram_rd_data,
    output ld_ready, ld_done, ld_addr,
    output cpu_rd_ready, cpu_rd_valid, cpu_rd_data,
    output sram_ce_bar, sram_we_bar, sram_addr, sram_wr_data
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences the program/data SRAM and
// arbitrates it between the program loader and CPU reads.
module sram_access_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  sram_access_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_ADDR,
    RD_CAPTURE
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
  logic                  ld_done_q, ld_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ce_bar_q, ce_bar_d;
  logic                  we_bar_q, we_bar_d;
  logic                  idle;
  logic                  prog_entry;
  logic                  ld_ready;
  logic                  cpu_rd_ready;

  assign idle         = (state_q == IDLE);
  assign prog_entry   = !bus.run_not_prog && mode_q;
  assign ld_ready     = idle && !bus.run_not_prog
                        && !ld_done_q;
  assign cpu_rd_ready = idle && bus.run_not_prog;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state, bus latching and registered strobe decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (ld_ready && bus.ld_valid) begin
          state_d = WR_SETUP;
          // a byte taken on the entry cycle belongs at 0
          addr_d  = prog_entry ? '0 : ld_addr_q;
          wdata_d = bus.ld_data;
        end else if (cpu_rd_ready && bus.cpu_rd_req) begin
          state_d = RD_ADDR;
          addr_d  = bus.cpu_addr;
        end
      end
      WR_SETUP:   state_d = WR_STROBE;
      WR_STROBE:  state_d = WR_HOLD;
      WR_HOLD:    state_d = IDLE;
      RD_ADDR:    state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    ce_bar_d = !(state_d inside
                 {WR_STROBE, RD_ADDR, RD_CAPTURE});
    we_bar_d = (state_d != WR_STROBE);
    rvalid_d = (state_q == RD_CAPTURE);
    rdata_d  = rvalid_d ? bus.sram_rd_data : rdata_q;
  end

  // loader address/done tracking; program entry wins
  always_comb begin
    ld_addr_d = ld_addr_q;
    ld_done_d = ld_done_q;
    if (state_q == WR_HOLD) begin
      ld_addr_d = ld_addr_q + 1'b1;
      if (ld_addr_q == LAST_ADDR) ld_done_d = 1'b1;
    end
    if (prog_entry) begin
      ld_addr_d = '0;
      ld_done_d = 1'b0;
    end
  end

  // datapath and strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 1'b1;
      ld_addr_q <= '0;
      ld_done_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      ce_bar_q  <= 1'b1;
      we_bar_q  <= 1'b1;
    end else begin
      mode_q    <= bus.run_not_prog;
      ld_addr_q <= ld_addr_d;
      ld_done_q <= ld_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      ce_bar_q  <= ce_bar_d;
      we_bar_q  <= we_bar_d;
    end
  end

  assign bus.ld_ready     = ld_ready;
  assign bus.ld_done      = ld_done_q;
  assign bus.ld_addr      = ld_addr_q;
  assign bus.cpu_rd_ready = cpu_rd_ready;
  assign bus.cpu_rd_valid = rvalid_q;
  assign bus.cpu_rd_data  = rdata_q;
  assign bus.sram_ce_bar  = ce_bar_q;
  assign bus.sram_we_bar  = we_bar_q;
  assign bus.sram_addr    = addr_q;
  assign bus.sram_wr_data = wdata_q;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: scoreboard bench for the SRAM access
// controller with a behavioural 16x8 SRAM attached.
module tb_sram_access_ctrl;
  logic clk = 1'b0;
  logic rst;

  sram_access_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  sram_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sram_mem [16];
  always @(posedge clk)
    if (!bus.sram_ce_bar && !bus.sram_we_bar)
      sram_mem[bus.sram_addr] <= bus.sram_wr_data;
  assign bus.sram_rd_data =
    (!bus.sram_ce_bar && bus.sram_we_bar) ?
    sram_mem[bus.sram_addr] : 8'h00;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  int         tq[$];
  logic [7:0] ref_mem [16];
  logic [3:0] m_addr;
  bit         prev_run;
  bit         prev_stb;
  int         strobe_cnt;
  int         rvalid_cnt;
  int         total;
  int         bad;

  task automatic monitor();
    wr_t        e;
    logic [7:0] ed;
    int         t;
    bit         stb;
    bit         entry;
    forever begin
      @(negedge clk);
      if (rst) begin
        wq.delete();
        rq.delete();
        tq.delete();
        m_addr   = 4'd0;
        prev_run = 1'b1;
        prev_stb = 1'b0;
      end else begin
        stb   = !bus.sram_ce_bar && !bus.sram_we_bar;
        entry = !bus.run_not_prog && prev_run;
        if (entry) m_addr = 4'd0;
        if (bus.ld_valid && bus.ld_ready) begin
          if (!entry) begin
            total++;
            if (bus.ld_addr !== m_addr) begin
              bad++;
              $display("FAIL ld_addr: got %0d want %0d",
                       bus.ld_addr, m_addr);
            end
          end
          e.a = m_addr;
          e.d = bus.ld_data;
          wq.push_back(e);
          m_addr = m_addr + 4'd1;
        end
        total++;
        if (bus.sram_ce_bar === 1'b1 && bus.sram_we_bar === 1'b0) begin
          bad++;
          $display("FAIL we_without_ce: ce_bar=1 we_bar=0");
        end
        if (stb) begin
          strobe_cnt++;
          total++;
          if (prev_stb) begin
            bad++;
            $display("FAIL strobe_width: got >1 cycle want 1");
          end
          total++;
          if (wq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: addr=%0d data=%h",
                     bus.sram_addr, bus.sram_wr_data);
          end else begin
            e = wq.pop_front();
            if (bus.sram_addr !== e.a ||
                bus.sram_wr_data !== e.d) begin
              bad++;
              $display("FAIL write: got %0d/%h want %0d/%h",
                       bus.sram_addr, bus.sram_wr_data, e.a, e.d);
            end
            ref_mem[e.a] = e.d;
          end
        end
        prev_stb = stb;
        if (bus.cpu_rd_valid) begin
          rvalid_cnt++;
          total++;
          if (rq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rd_valid: data=%h",
                     bus.cpu_rd_data);
          end else begin
            ed = rq.pop_front();
            t  = tq.pop_front();
            if (bus.cpu_rd_data !== ed) begin
              bad++;
              $display("FAIL rd_data: got %h want %h",
                       bus.cpu_rd_data, ed);
            end
            total++;
            if (cyc - t != 3) begin
              bad++;
              $display("FAIL rd_latency: got %0d want 3", cyc - t);
            end
          end
        end
        if (bus.cpu_rd_req && bus.cpu_rd_ready) begin
          rq.push_back(ref_mem[bus.cpu_addr]);
          tq.push_back(cyc);
        end
        prev_run = bus.run_not_prog;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output int hs);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    hs = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ld_valid && bus.ld_ready) begin
        hs = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_req(input logic [3:0] a, output int hs);
    bus.cpu_rd_req = 1'b1;
    bus.cpu_addr   = a;
    hs = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cpu_rd_req && bus.cpu_rd_ready) begin
        hs = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.run_not_prog = 1'b1;
    bus.ld_valid     = 1'b0;
    bus.ld_data      = 8'h00;
    bus.cpu_rd_req   = 1'b0;
    bus.cpu_addr     = 4'd0;
    @(posedge clk);
    #1;
    total++;
    if (bus.sram_ce_bar !== 1'b1 || bus.sram_we_bar !== 1'b1) begin
      bad++;
      $display("FAIL reset_strobe1: got %b%b want 11",
               bus.sram_ce_bar, bus.sram_we_bar);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.sram_ce_bar !== 1'b1 || bus.sram_we_bar !== 1'b1) begin
      bad++;
      $display("FAIL reset_strobe2: got %b%b want 11",
               bus.sram_ce_bar, bus.sram_we_bar);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.sram_addr !== 4'd0 || bus.sram_wr_data !== 8'h00 ||
        bus.ld_addr !== 4'd0 || bus.ld_done !== 1'b0 ||
        bus.cpu_rd_valid !== 1'b0 || bus.cpu_rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_values: got a=%0d w=%h la=%0d ld=%b v=%b d=%h want zeros",
               bus.sram_addr, bus.sram_wr_data, bus.ld_addr,
               bus.ld_done, bus.cpu_rd_valid, bus.cpu_rd_data);
    end
    total++;
    if (bus.ld_ready !== 1'b0 || bus.cpu_rd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got ld=%b cpu=%b want 0/1",
               bus.ld_ready, bus.cpu_rd_ready);
    end
  endtask

  task automatic test_stream8();
    int h[8];
    int s0;
    @(posedge clk);
    #1;
    bus.run_not_prog = 1'b0;
    bus.ld_valid     = 1'b0;
    @(posedge clk);
    #1;
    s0 = strobe_cnt;
    for (int k = 0; k < 8; k++) begin
      send_byte(8'((k + 1) * 17), h[k]);
      total++;
      if (h[k] < 0) begin
        bad++;
        $display("FAIL stream8_timeout: byte %0d not accepted", k);
      end else if (k > 0 && h[k-1] >= 0) begin
        total++;
        if (h[k] - h[k-1] != 4) begin
          bad++;
          $display("FAIL stream8_rate: got %0d want 4",
                   h[k] - h[k-1]);
        end
      end
    end
    bus.ld_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (bus.ld_addr !== 4'd8) begin
      bad++;
      $display("FAIL stream8_ld_addr: got %0d want 8", bus.ld_addr);
    end
    total++;
    if (strobe_cnt - s0 != 8 || wq.size() != 0) begin
      bad++;
      $display("FAIL stream8_writes: got %0d pend %0d want 8/0",
               strobe_cnt - s0, wq.size());
    end
  endtask

  task automatic test_full_load();
    int h;
    int s0;
    @(posedge clk);
    #1;
    bus.run_not_prog = 1'b1;
    @(posedge clk);
    #1;
    bus.run_not_prog = 1'b0;
    @(posedge clk);
    #1;
    s0 = strobe_cnt;
    for (int k = 0; k < 16; k++) begin
      send_byte(8'($urandom % 255), h);
      total++;
      if (h < 0) begin
        bad++;
        $display("FAIL full_timeout: byte %0d not accepted", k);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bus.ld_ready !== 1'b0) begin
        bad++;
        $display("FAIL full_ld_ready: got 1 want 0 at %0d", i);
      end
      if (i == 2) begin
        total++;
        if (bus.ld_done !== 1'b0) begin
          bad++;
          $display("FAIL full_done_early: got 1 want 0");
        end
      end
      if (i == 3) begin
        total++;
        if (bus.ld_done !== 1'b1 || bus.ld_addr !== 4'd0) begin
          bad++;
          $display("FAIL full_done: got %b/%0d want 1/0",
                   bus.ld_done, bus.ld_addr);
        end
      end
    end
    total++;
    if (strobe_cnt - s0 != 16) begin
      bad++;
      $display("FAIL full_writes: got %0d want 16", strobe_cnt - s0);
    end
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int h;
    int hp;
    int r0;
    int s0;
    bus.run_not_prog = 1'b1;
    @(posedge clk);
    #1;
    r0 = rvalid_cnt;
    s0 = strobe_cnt;
    hp = -1;
    for (int a = 0; a < 16; a++) begin
      read_req(4'(a), h);
      total++;
      if (h < 0) begin
        bad++;
        $display("FAIL b2b_timeout: addr %0d not accepted", a);
      end else if (hp >= 0) begin
        total++;
        if (h - hp != 3) begin
          bad++;
          $display("FAIL b2b_gap: got %0d want 3", h - hp);
        end
      end
      hp = h;
    end
    bus.cpu_rd_req = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (rvalid_cnt - r0 != 16 || rq.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d pend %0d want 16/0",
               rvalid_cnt - r0, rq.size());
    end
    total++;
    if (strobe_cnt != s0) begin
      bad++;
      $display("FAIL b2b_no_write: got %0d want 0", strobe_cnt - s0);
    end
  endtask

  task automatic test_mode_switch();
    int h;
    int h2;
    int r0;
    @(posedge clk);
    #1;
    bus.run_not_prog = 1'b0;
    @(posedge clk);
    #1;
    r0 = rvalid_cnt;
    send_byte(8'h5A, h);
    bus.ld_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.run_not_prog = 1'b1;
    read_req(4'd0, h2);
    bus.cpu_rd_req = 1'b0;
    total++;
    if (h < 0 || h2 - h != 4) begin
      bad++;
      $display("FAIL mode_rd_accept: got %0d want 4", h2 - h);
    end
    repeat (3) @(negedge clk);
    total++;
    if (rvalid_cnt - r0 != 1 || ref_mem[0] !== 8'h5A) begin
      bad++;
      $display("FAIL mode_readback: got %0d/%h want 1/5a",
               rvalid_cnt - r0, ref_mem[0]);
    end
    total++;
    if (bus.ld_addr !== 4'd1) begin
      bad++;
      $display("FAIL mode_ld_addr: got %0d want 1", bus.ld_addr);
    end
    @(posedge clk);
    #1;
    bus.run_not_prog = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.ld_addr !== 4'd0 || bus.ld_done !== 1'b0 ||
        bus.ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL mode_entry_clear: got %0d/%b/%b want 0/0/1",
               bus.ld_addr, bus.ld_done, bus.ld_ready);
    end
  endtask

  task automatic test_reset_mid_read();
    int h;
    int r0;
    @(posedge clk);
    #1;
    bus.run_not_prog = 1'b1;
    @(posedge clk);
    #1;
    r0 = rvalid_cnt;
    read_req(4'd3, h);
    bus.cpu_rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (h < 0 || bus.sram_ce_bar !== 1'b0 ||
        bus.sram_we_bar !== 1'b1) begin
      bad++;
      $display("FAIL rstrd_in_rd_addr: got hs=%0d %b%b want 01",
               h, bus.sram_ce_bar, bus.sram_we_bar);
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.sram_ce_bar !== 1'b1 || bus.sram_we_bar !== 1'b1 ||
        bus.cpu_rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstrd_strobes: got %b%b v=%b want 11 v=0",
               bus.sram_ce_bar, bus.sram_we_bar, bus.cpu_rd_valid);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (rvalid_cnt != r0 || bus.cpu_rd_ready !== 1'b1 ||
        bus.cpu_rd_data !== 8'h00) begin
      bad++;
      $display("FAIL rstrd_idle: got v=%0d rdy=%b d=%h want 0/1/00",
               rvalid_cnt - r0, bus.cpu_rd_ready, bus.cpu_rd_data);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    strobe_cnt = 0;
    rvalid_cnt = 0;
    m_addr     = 4'd0;
    prev_run   = 1'b1;
    prev_stb   = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_stream8();
    test_full_load();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sequences the 16x8 program/data SRAM and arbitrates it between the program loader and the CPU read path.
- The SRAM has active-low ce_bar and we_bar strobes.
- In program mode (run_not_prog=0), the block accepts a byte stream and writes it to consecutive addresses starting at 0.
- In run mode (run_not_prog=1), it services single-byte CPU reads addressed by the MAR.
- All SRAM strobes are generated here; nothing else drives the SRAM pins.

Parameters:
- ADDR_WIDTH, 4: SRAM address width.
- DATA_WIDTH, 8: SRAM data width.
- DEPTH, 2**ADDR_WIDTH: word count. Derived; must not be overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run_not_prog  in  1  mode: 1=run (CPU reads), 0=program (loader writes).
- ld_valid  in  1  loader byte valid.
- ld_data  in  DATA_WIDTH  loader byte.
- ld_ready  out  1  loader byte accepted when ld_valid&&ld_ready.
- ld_done  out  1  sticky: all DEPTH words written this program session.
- ld_addr  out  ADDR_WIDTH  address the next loader byte will be written to.
- cpu_rd_req  in  1  CPU read request.
- cpu_addr  in  ADDR_WIDTH  CPU read address (MAR).
- cpu_rd_ready  out  1  CPU request accepted when cpu_rd_req&&cpu_rd_ready.
- cpu_rd_valid  out  1  one-cycle pulse; cpu_rd_data valid.
- cpu_rd_data  out  DATA_WIDTH  registered read data, held until the next read.
- sram_ce_bar  out  1  SRAM chip enable, active low.
- sram_we_bar  out  1  SRAM write enable, active low.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_wr_data  out  DATA_WIDTH  SRAM write data.
- sram_rd_data  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset:
  - State is IDLE.
  - sram_ce_bar=1, sram_we_bar=1, sram_addr=0, sram_wr_data=0.
  - ld_addr=0, ld_done=0, cpu_rd_valid=0, cpu_rd_data=0.
  - mode_q=1, so the first cycle after reset with run_not_prog=0 counts as program entry.
  - Reset mid-transaction aborts it immediately; strobes return high on that same edge.
- Ready signals (combinational from state):
  - ld_ready = IDLE && !run_not_prog && !ld_done.
  - cpu_rd_ready = IDLE && run_not_prog.
  - Both are 0 in every other state, so only one side is ever ready.
- FSM states: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_ADDR, RD_CAPTURE.
- Write sequence:
  - IDLE with a loader handshake: latch sram_addr=ld_addr and sram_wr_data=ld_data, then go to WR_SETUP (ce_bar=1, we_bar=1).
  - WR_SETUP -> WR_STROBE: ce_bar=0, we_bar=0 for exactly one cycle.
  - WR_STROBE -> WR_HOLD: ce_bar=1, we_bar=1; addr and data held.
  - WR_HOLD -> IDLE: ld_addr increments.
  - Throughput is one byte per 4 cycles.
- Loader addressing:
  - When a write to address DEPTH-1 completes, ld_addr wraps to 0 and ld_done is set.
  - ld_done stays set; ld_ready remains 0 until the next program entry.
- Read sequence:
  - IDLE with a CPU handshake: latch sram_addr=cpu_addr, then go to RD_ADDR (ce_bar=0, we_bar=1).
  - RD_ADDR -> RD_CAPTURE: ce_bar=0; cpu_rd_data <= sram_rd_data at the end of this cycle.
  - cpu_rd_valid=1 in the following cycle, which is back in IDLE.
  - Latency: handshake at edge N, cpu_rd_valid high in cycle N+3. A new request can be accepted in that same cycle.
- sram_we_bar is never 0 while sram_ce_bar=1. The strobe is never asserted in IDLE.
- Mode handling:
  - run_not_prog is sampled into mode_q every cycle.
  - Program entry is run_not_prog==0 && mode_q==1. It clears ld_addr and ld_done in any state.
  - If program entry coincides with the WR_HOLD increment, the clear wins.
  - A mode change during a transaction does not abort it; the transaction completes, and the new mode applies from IDLE.
- Simultaneous ld_valid and cpu_rd_req: only the side matching the current mode is accepted; the other waits (its ready stays 0).

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs at their reset values; sram_ce_bar=1 and sram_we_bar=1 throughout.
- Program mode, stream 0x11,0x22,...,0x88 (8 bytes) with ld_valid held high:
  - ld_ready pulses once every 4 cycles.
  - Each byte gets exactly one cycle with ce_bar=0 and we_bar=0, at addresses 0..7.
  - ld_addr ends at 8.
- Program 16 random bytes ($urandom % 255) -> ld_done=1 after the 16th WR_HOLD, ld_addr=0, ld_ready stays 0 for a 17th ld_valid, and no SRAM write occurs.
- Switch to run mode and read addresses 0..15 back-to-back -> each cpu_rd_data matches the byte written, cpu_rd_valid exactly 3 cycles after each handshake, and we_bar=1 throughout.
- Set run_not_prog 0->1 during WR_STROBE:
  - The write completes and data is readable at that address.
  - The next cpu_rd_req is accepted only after WR_HOLD.
  - Returning to 0 clears ld_addr and ld_done.
- Assert rst during RD_ADDR -> strobes go high on that edge, cpu_rd_valid never pulses, and the FSM is in IDLE.
